// File: rtl/gshare_bp_param.sv
// rtl/gshare_bp_param.sv - gshare predictor, tagged BTB, init sweep FSM; BP_STATS_EN enables stat counters
module gshare_bp_param #(
  parameter int         DBITS        = 32,
  parameter int         HIST_BITS    = 8,
  parameter int         PHT_IDX_BITS = 8,
  parameter int         BTB_IDX_BITS = 4,
  parameter logic [1:0] CTR_INIT     = 2'b01
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    bp_flush,
  output logic                    bp_ready,
  input  logic                    pred_val,
  input  logic [DBITS-1:0]        pred_pc,
  output logic                    pred_taken,
  output logic [DBITS-1:0]        pred_target,
  output logic [PHT_IDX_BITS-1:0] pred_idx,
  input  logic                    upd_val,
  input  logic [PHT_IDX_BITS-1:0] upd_idx,
  input  logic [DBITS-1:0]        upd_pc,
  input  logic                    upd_taken,
  input  logic [DBITS-1:0]        upd_target,
  input  logic                    upd_mispred,
  output logic [31:0]             stat_lookups,
  output logic [31:0]             stat_updates,
  output logic [31:0]             stat_mispred
);

  localparam int PHT_DEPTH = 2 ** PHT_IDX_BITS;
  localparam int BTB_DEPTH = 2 ** BTB_IDX_BITS;
  localparam int TAG_W     = DBITS - BTB_IDX_BITS - 2;

  if (HIST_BITS > PHT_IDX_BITS || BTB_IDX_BITS > PHT_IDX_BITS) begin : g_bad_params
    $error("gshare_bp_param: HIST_BITS and BTB_IDX_BITS must not exceed PHT_IDX_BITS");
  end

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state_q, state_d;
  logic [PHT_IDX_BITS-1:0] init_cnt_q, init_cnt_d;
  logic [HIST_BITS-1:0]    ghr_q, ghr_d;

  logic [1:0]       ctr        [PHT_DEPTH];
  logic             btb_valid  [BTB_DEPTH];
  logic [TAG_W-1:0] btb_tag    [BTB_DEPTH];
  logic [DBITS-1:0] btb_target [BTB_DEPTH];

  logic                    upd_accept;
  logic                    init_in_btb;
  logic [BTB_IDX_BITS-1:0] init_bidx;
  logic [BTB_IDX_BITS-1:0] upd_bidx;
  logic [TAG_W-1:0]        upd_tag;
  logic [BTB_IDX_BITS-1:0] lk_bidx;
  logic [TAG_W-1:0]        lk_tag;
  logic                    lk_hit;
  logic                    unused_ok;

  assign bp_ready    = (state_q == ST_RUN);
  assign upd_accept  = bp_ready && upd_val && !bp_flush;
  assign init_in_btb = (32'(init_cnt_q) < 32'(BTB_DEPTH));
  assign init_bidx   = init_cnt_q[BTB_IDX_BITS-1:0];
  assign upd_bidx    = upd_pc[BTB_IDX_BITS+1:2];
  assign upd_tag     = upd_pc[DBITS-1:BTB_IDX_BITS+2];
  assign unused_ok   = ^{pred_pc[1:0], upd_pc[1:0], upd_mispred};

  // Zero-latency lookup; sees table state from before any same-cycle update
  assign pred_idx    = pred_pc[PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(ghr_q);
  assign lk_bidx     = pred_pc[BTB_IDX_BITS+1:2];
  assign lk_tag      = pred_pc[DBITS-1:BTB_IDX_BITS+2];
  assign lk_hit      = btb_valid[lk_bidx] && (btb_tag[lk_bidx] == lk_tag);
  assign pred_taken  = pred_val && bp_ready && ctr[pred_idx][1] && lk_hit;
  assign pred_target = pred_taken ? btb_target[lk_bidx] : pred_pc + DBITS'(4);

  // FSM, sweep counter and history registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      ghr_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ghr_q      <= ghr_d;
    end
  end

  // Next state: flush always restarts the sweep; history shifts only on accepted updates
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    ghr_d      = ghr_q;
    if (bp_flush) begin
      state_d    = ST_INIT;
      init_cnt_d = '0;
      ghr_d      = '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_cnt_d = init_cnt_q + PHT_IDX_BITS'(1);
          if (init_cnt_q == '1) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (upd_val) ghr_d = {ghr_q[HIST_BITS-2:0], upd_taken};
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  // Table storage: one entry swept per INIT cycle, otherwise trained by accepted updates
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      ctr[init_cnt_q] <= CTR_INIT;
      if (init_in_btb) btb_valid[init_bidx] <= 1'b0;
    end else if (upd_accept) begin
      if (upd_taken) begin
        if (ctr[upd_idx] != 2'b11) ctr[upd_idx] <= ctr[upd_idx] + 2'b01;
        btb_valid[upd_bidx]  <= 1'b1;
        btb_tag[upd_bidx]    <= upd_tag;
        btb_target[upd_bidx] <= upd_target;
      end else begin
        if (ctr[upd_idx] != 2'b00) ctr[upd_idx] <= ctr[upd_idx] - 2'b01;
      end
    end
  end

`ifdef BP_STATS_EN
  // Saturating event counters, cleared by reset or flush
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_lookups <= '0;
      stat_updates <= '0;
      stat_mispred <= '0;
    end else if (bp_flush) begin
      stat_lookups <= '0;
      stat_updates <= '0;
      stat_mispred <= '0;
    end else begin
      if (pred_val && bp_ready && stat_lookups != '1) stat_lookups <= stat_lookups + 32'd1;
      if (upd_accept && stat_updates != '1) stat_updates <= stat_updates + 32'd1;
      if (upd_accept && upd_mispred && stat_mispred != '1) stat_mispred <= stat_mispred + 32'd1;
    end
  end
`else
  assign stat_lookups = '0;
  assign stat_updates = '0;
  assign stat_mispred = '0;
`endif

endmodule

// File: tb/tb_gshare_bp_param.sv
// tb/tb_gshare_bp_param.sv - directed self-checking bench for gshare_bp_param
module tb_gshare_bp_param;

  logic        clk;
  logic        reset_n;
  logic        bp_flush;
  logic        bp_ready;
  logic        pred_val;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [7:0]  pred_idx;
  logic        upd_val;
  logic [7:0]  upd_idx;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispred;
  logic [31:0] stat_lookups;
  logic [31:0] stat_updates;
  logic [31:0] stat_mispred;

  int checks;
  int failures;

  gshare_bp_param dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bp_flush    (bp_flush),
    .bp_ready    (bp_ready),
    .pred_val    (pred_val),
    .pred_pc     (pred_pc),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .pred_idx    (pred_idx),
    .upd_val     (upd_val),
    .upd_idx     (upd_idx),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .upd_mispred (upd_mispred),
    .stat_lookups(stat_lookups),
    .stat_updates(stat_updates),
    .stat_mispred(stat_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_update(input logic [7:0] idx, input logic [31:0] pc, input logic tk,
                           input logic [31:0] tgt, input logic mp);
    upd_val     = 1'b1;
    upd_idx     = idx;
    upd_pc      = pc;
    upd_taken   = tk;
    upd_target  = tgt;
    upd_mispred = mp;
    tick();
    upd_val     = 1'b0;
    upd_mispred = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (bp_ready) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    pred_val = 1'b1;
    pred_pc  = 32'h100;
    repeat (3) tick();
    checks++; if (bp_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bp_ready); end
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL reset_taken got=%b exp=0", pred_taken); end
    checks++; if (pred_target !== 32'h104) begin failures++; $display("FAIL reset_target got=%h exp=00000104", pred_target); end
    checks++; if (stat_lookups !== 32'd0 || stat_updates !== 32'd0 || stat_mispred !== 32'd0) begin
      failures++; $display("FAIL reset_stats got=%0d/%0d/%0d exp=0/0/0", stat_lookups, stat_updates, stat_mispred);
    end
    reset_n = 1'b1;
    wait_ready(n);
    checks++; if (n !== 256) begin failures++; $display("FAIL init_ready_cycle got=%0d exp=256", n); end
    pred_pc = 32'h100;
    #1;
    checks++; if (pred_idx !== 8'h40) begin failures++; $display("FAIL run_idx_0x100 got=%h exp=40", pred_idx); end
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL run_taken_0x100 got=%b exp=0", pred_taken); end
    checks++; if (pred_target !== 32'h104) begin failures++; $display("FAIL run_target_0x100 got=%h exp=00000104", pred_target); end
  endtask

  task automatic test_train();
    pred_val = 1'b0;
    do_update(8'h13, 32'h40, 1'b1, 32'h200, 1'b0);
    do_update(8'h13, 32'h40, 1'b1, 32'h200, 1'b0);
    pred_val = 1'b1;
    pred_pc  = 32'h40;
    #1;
    checks++; if (pred_idx !== 8'h13) begin failures++; $display("FAIL train_idx got=%h exp=13", pred_idx); end
    checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL train_taken got=%b exp=1", pred_taken); end
    checks++; if (pred_target !== 32'h200) begin failures++; $display("FAIL train_target got=%h exp=00000200", pred_target); end
    pred_val = 1'b0;
    #1;
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL noval_taken got=%b exp=0", pred_taken); end
    checks++; if (pred_target !== 32'h44) begin failures++; $display("FAIL noval_target got=%h exp=00000044", pred_target); end
  endtask

  task automatic test_tag_mismatch();
    pred_val = 1'b1;
    pred_pc  = 32'h440;
    #1;
    checks++; if (pred_idx !== 8'h13) begin failures++; $display("FAIL tagmis_idx got=%h exp=13", pred_idx); end
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL tagmis_taken got=%b exp=0", pred_taken); end
    checks++; if (pred_target !== 32'h444) begin failures++; $display("FAIL tagmis_target got=%h exp=00000444", pred_target); end
  endtask

  task automatic test_saturate();
    pred_val = 1'b0;
    for (int i = 0; i < 5; i++) do_update(8'h13, 32'h40, 1'b0, 32'h0, 1'b0);
    do_update(8'h13, 32'h348, 1'b1, 32'h500, 1'b0);
    // GHR now 0xC1; pc 0x348 maps to 0xD2 ^ 0xC1 = 0x13 and hits the fresh BTB entry
    pred_val = 1'b1;
    pred_pc  = 32'h348;
    #1;
    checks++; if (pred_idx !== 8'h13) begin failures++; $display("FAIL sat_idx got=%h exp=13", pred_idx); end
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL sat_taken got=%b exp=0", pred_taken); end
    checks++; if (pred_target !== 32'h34c) begin failures++; $display("FAIL sat_target got=%h exp=0000034c", pred_target); end
  endtask

  task automatic test_same_cycle();
    pred_val    = 1'b1;
    pred_pc     = 32'h348;
    upd_val     = 1'b1;
    upd_idx     = 8'h13;
    upd_pc      = 32'h240;
    upd_taken   = 1'b1;
    upd_target  = 32'h600;
    upd_mispred = 1'b0;
    #1;
    checks++; if (pred_idx !== 8'h13) begin failures++; $display("FAIL same_idx got=%h exp=13", pred_idx); end
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL same_taken got=%b exp=0", pred_taken); end
    checks++; if (pred_target !== 32'h34c) begin failures++; $display("FAIL same_target got=%h exp=0000034c", pred_target); end
    tick();
    upd_val = 1'b0;
    // GHR now 0x83; pc 0x240 maps to 0x90 ^ 0x83 = 0x13, BTB entry just written
    pred_pc = 32'h240;
    #1;
    checks++; if (pred_idx !== 8'h13) begin failures++; $display("FAIL next_idx got=%h exp=13", pred_idx); end
    checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL next_taken got=%b exp=1", pred_taken); end
    checks++; if (pred_target !== 32'h600) begin failures++; $display("FAIL next_target got=%h exp=00000600", pred_target); end
  endtask

  task automatic test_flush_init();
    int n;
    pred_val = 1'b0;
    bp_flush = 1'b1;
    tick();
    bp_flush = 1'b0;
    checks++; if (bp_ready !== 1'b0) begin failures++; $display("FAIL flush_ready_drop got=%b exp=0", bp_ready); end
    upd_idx    = 8'h10;
    upd_pc     = 32'h40;
    upd_taken  = 1'b1;
    upd_target = 32'h700;
    for (int i = 0; i < 100; i++) begin
      upd_val = (i % 2 == 0);
      tick();
    end
    bp_flush = 1'b1;
    upd_val  = 1'b1;
    tick();
    bp_flush = 1'b0;
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      upd_val = (i % 2 == 1);
      tick();
      if (bp_ready) begin
        n = i;
        break;
      end
    end
    upd_val = 1'b0;
    checks++; if (n !== 256) begin failures++; $display("FAIL reflush_ready_cycle got=%0d exp=256", n); end
    pred_val = 1'b1;
    pred_pc  = 32'h40;
    #1;
    checks++; if (pred_idx !== 8'h10) begin failures++; $display("FAIL flush_idx got=%h exp=10", pred_idx); end
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL flush_taken got=%b exp=0", pred_taken); end
    checks++; if (pred_target !== 32'h44) begin failures++; $display("FAIL flush_target got=%h exp=00000044", pred_target); end
    pred_val = 1'b0;
  endtask

  task automatic test_stats();
    int n;
    logic [31:0] exp_l, exp_u, exp_m;
`ifdef BP_STATS_EN
    exp_l = 32'd10; exp_u = 32'd4; exp_m = 32'd1;
`else
    exp_l = 32'd0;  exp_u = 32'd0; exp_m = 32'd0;
`endif
    pred_val = 1'b0;
    bp_flush = 1'b1;
    tick();
    bp_flush = 1'b0;
    wait_ready(n);
    checks++; if (n !== 256) begin failures++; $display("FAIL stats_ready_cycle got=%0d exp=256", n); end
    pred_pc  = 32'h80;
    pred_val = 1'b1;
    repeat (10) tick();
    pred_val = 1'b0;
    do_update(8'h01, 32'h80, 1'b1, 32'h300, 1'b0);
    do_update(8'h02, 32'h84, 1'b0, 32'h0,   1'b1);
    do_update(8'h03, 32'h88, 1'b1, 32'h310, 1'b0);
    do_update(8'h04, 32'h8c, 1'b0, 32'h0,   1'b0);
    checks++; if (stat_lookups !== exp_l) begin failures++; $display("FAIL stat_lookups got=%0d exp=%0d", stat_lookups, exp_l); end
    checks++; if (stat_updates !== exp_u) begin failures++; $display("FAIL stat_updates got=%0d exp=%0d", stat_updates, exp_u); end
    checks++; if (stat_mispred !== exp_m) begin failures++; $display("FAIL stat_mispred got=%0d exp=%0d", stat_mispred, exp_m); end
    bp_flush = 1'b1;
    tick();
    bp_flush = 1'b0;
    checks++; if (stat_lookups !== 32'd0 || stat_updates !== 32'd0 || stat_mispred !== 32'd0) begin
      failures++; $display("FAIL stat_flush got=%0d/%0d/%0d exp=0/0/0", stat_lookups, stat_updates, stat_mispred);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    bp_flush    = 1'b0;
    pred_val    = 1'b0;
    pred_pc     = 32'h0;
    upd_val     = 1'b0;
    upd_idx     = 8'h0;
    upd_pc      = 32'h0;
    upd_taken   = 1'b0;
    upd_target  = 32'h0;
    upd_mispred = 1'b0;
    test_reset();
    test_train();
    test_tag_mismatch();
    test_saturate();
    test_same_cycle();
    test_flush_init();
    test_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
